trig_dly_pipe: RTL and testbench

TRIG_DLY_PIPE -- requirements
Module: trig_dly_pipe

---
 rtl/trig_dly_pkg.sv | 16 +
 rtl/trig_dly_ring.sv | 32 +++
 rtl/trig_dly_pipe.sv | 151 +++++++++++++++
 tb/tb_trig_dly_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_dly_pkg.sv
// Shared constants for the trigger delay pipeline: ring geometry, kill codes,
// flush length and the two-state FSM encoding.
package trig_dly_pkg;

   localparam int RING_DEPTH = 32;
   localparam int PTR_W      = 5;
   localparam int FLUSH_LEN  = 32;

   localparam logic [2:0] KILL_NONE = 3'd0;
   localparam logic [2:0] KILL_L1A  = 3'd6;
   localparam logic [2:0] KILL_ALL  = 3'd7;

   localparam logic [0:0] ST_FLUSH = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/trig_dly_ring.sv
// 32 x 6 circular buffer holding {L1A, LCT[4:0]} history. One write port and
// two independently addressed read ports with registered data, small enough
// to map onto distributed RAM or shift-register primitives.
module trig_dly_ring
   import trig_dly_pkg::*;
#(
   parameter int DEPTH = RING_DEPTH
)
(
   input  logic             CLKCMS,
   input  logic [PTR_W-1:0] wr_ptr,
   input  logic [5:0]       wr_data,
   input  logic [PTR_W-1:0] rd_ptr_l1a,
   input  logic [PTR_W-1:0] rd_ptr_lct,
   output logic             rd_l1a,
   output logic [4:0]       rd_lct
);

   logic [5:0] mem [DEPTH];

   // Storage is deliberately not reset; stale entries are hidden by the flush.
   always_ff @(posedge CLKCMS) begin
      mem[wr_ptr] <= wr_data;
   end

   // Registered read ports; the read pointers never equal the write pointer.
   always_ff @(posedge CLKCMS) begin
      rd_l1a <= mem[rd_ptr_l1a][5];
      rd_lct <= mem[rd_ptr_lct][4:0];
   end

endmodule

// File: rtl/trig_dly_pipe.sv
// Trigger delay pipeline: delays L1A and the five LCT bits by programmable
// amounts through a shared ring buffer, applies a kill mask, counts issued
// L1As and blanks everything for a 32-cycle flush after reset or reconfig.
// With TMR=1 the FSM state, flush counter and write pointer are triplicated
// and majority voted.
module trig_dly_pipe
   import trig_dly_pkg::*;
#(
   parameter int TMR   = 0,
   parameter int DEPTH = 32
)
(
   input  logic        CLKCMS,
   input  logic        RST,
   input  logic        CFG_STB,
   input  logic [7:0]  CABLEDLY,
   input  logic [3:0]  L1FDLY,
   input  logic [2:0]  KILLIN,
   input  logic        L1A_IN,
   input  logic [4:0]  LCT_IN,
   output logic        L1A_DLY,
   output logic [4:0]  LCT_DLY,
   output logic        BUSY,
   output logic [15:0] L1A_CNT
);

   localparam int NCOPY = (TMR != 0) ? 3 : 1;

   logic [PTR_W-1:0] wp_q [NCOPY];
   logic [PTR_W-1:0] fc_q [NCOPY];
   logic [0:0]       st_q [NCOPY];

   logic [PTR_W-1:0] wp, fc;
   logic [0:0]       st;
   logic [PTR_W-1:0] wp_nxt, fc_nxt;
   logic [0:0]       st_nxt;

   logic [4:0] d_l1a;
   logic [3:0] d_lct;
   logic [2:0] kill;

   logic [PTR_W-1:0] rd_ptr_l1a, rd_ptr_lct;
   logic             rd_l1a;
   logic [4:0]       rd_lct;
   logic             l1a_masked;
   logic [4:0]       lct_masked;
   logic             run_out;

   if (TMR != 0) begin : g_vote
      assign wp = (wp_q[0] & wp_q[1]) | (wp_q[0] & wp_q[2]) | (wp_q[1] & wp_q[2]);
      assign fc = (fc_q[0] & fc_q[1]) | (fc_q[0] & fc_q[2]) | (fc_q[1] & fc_q[2]);
      assign st = (st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]);
   end else begin : g_single
      assign wp = wp_q[0];
      assign fc = fc_q[0];
      assign st = st_q[0];
   end

   // Next pointer / flush count / state; any config strobe restarts the flush.
   always_comb begin
      wp_nxt = wp + PTR_W'(1);
      fc_nxt = '0;
      st_nxt = st;
      if (CFG_STB) begin
         st_nxt = ST_FLUSH;
         fc_nxt = '0;
      end else if (st == ST_FLUSH) begin
         fc_nxt = fc + PTR_W'(1);
         st_nxt = (fc == PTR_W'(FLUSH_LEN - 1)) ? ST_RUN : ST_FLUSH;
      end
   end

   // Every redundant copy reloads from the voted next value, scrubbing upsets.
   always_ff @(posedge CLKCMS) begin
      for (int i = 0; i < NCOPY; i++) begin
         if (RST) begin
            wp_q[i] <= '0;
            fc_q[i] <= '0;
            st_q[i] <= ST_FLUSH;
         end else begin
            wp_q[i] <= wp_nxt;
            fc_q[i] <= fc_nxt;
            st_q[i] <= st_nxt;
         end
      end
   end

   // Shadow delay and kill settings; reset beats a simultaneous strobe.
   always_ff @(posedge CLKCMS) begin
      if (RST) begin
         d_l1a <= '0;
         d_lct <= '0;
         kill  <= KILL_NONE;
      end else if (CFG_STB) begin
         d_l1a <= {1'b0, CABLEDLY[3:0]} + {1'b0, L1FDLY};
         d_lct <= CABLEDLY[7:4];
         kill  <= KILLIN;
      end
   end

   // Reads are offset from the most recently written slot, so with the
   // registered read and registered output a delay of D costs D+2 clocks.
   assign rd_ptr_l1a = wp - PTR_W'(1) - d_l1a;
   assign rd_ptr_lct = wp - PTR_W'(1) - {1'b0, d_lct};

   trig_dly_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .CLKCMS     (CLKCMS),
      .wr_ptr     (wp),
      .wr_data    ({L1A_IN, LCT_IN}),
      .rd_ptr_l1a (rd_ptr_l1a),
      .rd_ptr_lct (rd_ptr_lct),
      .rd_l1a     (rd_l1a),
      .rd_lct     (rd_lct)
   );

   // Kill mask applied to the buffer read data.
   always_comb begin
      l1a_masked = rd_l1a;
      if (kill == KILL_L1A || kill == KILL_ALL) begin
         l1a_masked = 1'b0;
      end
      lct_masked = rd_lct;
      for (int i = 0; i < 5; i++) begin
         if (kill == KILL_ALL || kill == 3'(i + 1)) begin
            lct_masked[i] = 1'b0;
         end
      end
   end

   assign run_out = (st == ST_RUN) && !CFG_STB;

   // Registered outputs, blanked while flushing; BUSY tracks the next state.
   always_ff @(posedge CLKCMS) begin
      if (RST) begin
         L1A_DLY <= 1'b0;
         LCT_DLY <= '0;
         L1A_CNT <= '0;
         BUSY    <= 1'b1;
      end else begin
         L1A_DLY <= run_out ? l1a_masked : 1'b0;
         LCT_DLY <= run_out ? lct_masked : 5'd0;
         if (st == ST_RUN && L1A_DLY) begin
            L1A_CNT <= L1A_CNT + 16'd1;
         end
         BUSY    <= (st_nxt == ST_FLUSH);
      end
   end

endmodule

// File: tb/tb_trig_dly_pipe.sv
// Testbench for trig_dly_pipe: a timing model predicts every cycle's outputs
// into a scoreboard queue, a monitor pops and compares, and directed checks
// pin down the latencies, wraps and flush lengths with literal constants.
module tb_trig_dly_pipe;

   logic        CLKCMS   = 1'b0;
   logic        RST      = 1'b1;
   logic        CFG_STB  = 1'b0;
   logic [7:0]  CABLEDLY = 8'd0;
   logic [3:0]  L1FDLY   = 4'd0;
   logic [2:0]  KILLIN   = 3'd0;
   logic        L1A_IN   = 1'b0;
   logic [4:0]  LCT_IN   = 5'd0;
   logic        L1A_DLY;
   logic [4:0]  LCT_DLY;
   logic        BUSY;
   logic [15:0] L1A_CNT;

   int checks   = 0;
   int failures = 0;

   logic [22:0] exp_q [$];

   int          m_edge   = 0;
   int          last_ev  = 0;
   int          rst_edge = 0;
   int          md_l1a   = 0;
   int          md_lct   = 0;
   int          mkill    = 0;
   logic [15:0] m_cnt    = 16'd0;
   logic        m_prev   = 1'b0;
   logic        hist_l1a [64];
   logic [4:0]  hist_lct [64];

   logic [7:0]  cur_cab  = 8'd0;
   logic [3:0]  cur_l1f  = 4'd0;
   logic [2:0]  cur_kill = 3'd0;

   trig_dly_pipe #(
      .TMR   (0),
      .DEPTH (32)
   ) dut (
      .CLKCMS   (CLKCMS),
      .RST      (RST),
      .CFG_STB  (CFG_STB),
      .CABLEDLY (CABLEDLY),
      .L1FDLY   (L1FDLY),
      .KILLIN   (KILLIN),
      .L1A_IN   (L1A_IN),
      .LCT_IN   (LCT_IN),
      .L1A_DLY  (L1A_DLY),
      .LCT_DLY  (LCT_DLY),
      .BUSY     (BUSY),
      .L1A_CNT  (L1A_CNT)
   );

   always #5 CLKCMS = ~CLKCMS;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s t=%0t got=%h required=%h", name, $time, act, req);
      end
   endtask

   // Drive one clock's inputs, predict the outputs after that edge, then
   // return 1ns after the edge so callers can sample the DUT directly.
   task automatic applyStimulus(input logic rst, input logic cfg, input logic [7:0] cab,
                                input logic [3:0] l1f, input logic [2:0] kill,
                                input logic l1a, input logic [4:0] lct);
      int         age;
      logic       e_l1a;
      logic [4:0] e_lct;
      @(negedge CLKCMS);
      RST = rst; CFG_STB = cfg; CABLEDLY = cab; L1FDLY = l1f; KILLIN = kill;
      L1A_IN = l1a; LCT_IN = lct;
      hist_l1a[m_edge % 64] = l1a;
      hist_lct[m_edge % 64] = lct;
      if (rst) begin
         md_l1a = 0; md_lct = 0; mkill = 0;
         last_ev = m_edge; rst_edge = m_edge; m_cnt = 16'd0;
      end else begin
         m_cnt = m_cnt + 16'(m_prev);
         if (cfg) begin
            md_l1a  = int'(cab[3:0]) + int'(l1f);
            md_lct  = int'(cab[7:4]);
            mkill   = int'(kill);
            last_ev = m_edge;
         end
      end
      age   = m_edge - last_ev;
      e_l1a = 1'b0;
      e_lct = 5'd0;
      if (age >= 33) begin
         e_l1a = hist_l1a[(m_edge - 2 - md_l1a) % 64] && !(mkill == 6 || mkill == 7);
         for (int i = 0; i < 5; i++) begin
            e_lct[i] = hist_lct[(m_edge - 2 - md_lct) % 64][i] && !(mkill == i + 1 || mkill == 7);
         end
      end
      exp_q.push_back({e_l1a, e_lct, (age < 32), m_cnt});
      m_prev = e_l1a;
      m_edge++;
      @(posedge CLKCMS);
      #1;
   endtask

   task automatic cycle(input logic l1a, input logic [4:0] lct);
      applyStimulus(1'b0, 1'b0, cur_cab, cur_l1f, cur_kill, l1a, lct);
   endtask

   task automatic configure(input logic [7:0] cab, input logic [3:0] l1f, input logic [2:0] kill);
      cur_cab = cab; cur_l1f = l1f; cur_kill = kill;
      applyStimulus(1'b0, 1'b1, cab, l1f, kill, 1'b0, 5'd0);
      for (int i = 0; i < 33; i++) cycle(1'b0, 5'd0);
   endtask

   // Scoreboard monitor: one full output comparison per predicted edge.
   initial begin
      logic [22:0] exp_v;
      forever begin
         @(posedge CLKCMS);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checkOutput("scoreboard", {9'd0, L1A_DLY, LCT_DLY, BUSY, L1A_CNT}, {9'd0, exp_v});
         end
      end
   end

   initial begin
      int   busy_n;
      logic quiet;

      // Reset then idle: BUSY high for exactly 32 samples, outputs quiet.
      applyStimulus(1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 1'b0, 5'd0);
      busy_n = BUSY ? 1 : 0;
      quiet  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 5'd0);
         if (BUSY) busy_n++;
         if (L1A_DLY || LCT_DLY != 5'd0) quiet = 1'b0;
      end
      checkOutput("reset_busy_len", busy_n, 32);
      checkOutput("reset_quiet", quiet, 1);
      checkOutput("reset_cnt", L1A_CNT, 0);

      // D_L1A = 5+4 = 9 (latency 11), D_LCT = 3 (latency 5).
      configure(8'h35, 4'd4, 3'd0);
      cycle(1'b1, 5'b00001);
      for (int k = 1; k <= 12; k++) begin
         cycle(1'b0, 5'd0);
         if (k == 4)  checkOutput("lct_not_early", LCT_DLY, 0);
         if (k == 5)  checkOutput("lct_latency5", LCT_DLY, 1);
         if (k == 10) checkOutput("l1a_not_early", L1A_DLY, 0);
         if (k == 11) checkOutput("l1a_latency11", L1A_DLY, 1);
         if (k == 12) checkOutput("cnt_one", L1A_CNT, 1);
      end

      // D_L1A = 30, three pulses written at slots 31, 0, 1.
      configure(8'h0F, 4'hF, 3'd0);
      while (((m_edge - rst_edge) % 32) != 0) cycle(1'b0, 5'd0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 5'd0);
      for (int k = 1; k <= 33; k++) begin
         cycle(1'b0, 5'd0);
         if (k == 29) checkOutput("wrap_before", L1A_DLY, 0);
         if (k >= 30 && k <= 32) checkOutput("wrap_pulse", L1A_DLY, 1);
         if (k == 33) begin
            checkOutput("wrap_after", L1A_DLY, 0);
            checkOutput("wrap_cnt", L1A_CNT, 4);
         end
      end

      // Kill code 6 masks only L1A; code 3 masks LCT bit 2.
      configure(8'h00, 4'd0, 3'd6);
      for (int k = 0; k < 4; k++) cycle(1'b1, 5'h1F);
      checkOutput("kill6_l1a", L1A_DLY, 0);
      checkOutput("kill6_lct", LCT_DLY, 5'b11111);
      configure(8'h00, 4'd0, 3'd3);
      for (int k = 0; k < 4; k++) cycle(1'b1, 5'h1F);
      checkOutput("kill3_l1a", L1A_DLY, 1);
      checkOutput("kill3_lct", LCT_DLY, 5'b11011);
      for (int k = 0; k < 3; k++) cycle(1'b0, 5'd0);

      // Re-strobe at FC=20 restarts a full 32-cycle flush with new delays.
      cur_cab = 8'h35; cur_l1f = 4'd4; cur_kill = 3'd0;
      applyStimulus(1'b0, 1'b1, cur_cab, cur_l1f, cur_kill, 1'b0, 5'd0);
      for (int k = 0; k < 20; k++) cycle(1'b0, 5'd0);
      cur_cab = 8'h12; cur_l1f = 4'd0;
      applyStimulus(1'b0, 1'b1, cur_cab, cur_l1f, cur_kill, 1'b0, 5'd0);
      busy_n = BUSY ? 1 : 0;
      for (int k = 0; k < 39; k++) begin
         cycle(1'b0, 5'd0);
         if (BUSY) busy_n++;
      end
      checkOutput("restrobe_busy_len", busy_n, 32);
      cycle(1'b1, 5'b00001);
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b0, 5'd0);
         if (k == 3) checkOutput("restrobe_lct3", LCT_DLY, 1);
         if (k == 4) checkOutput("restrobe_l1a4", L1A_DLY, 1);
      end

      // Reset (with a simultaneous strobe) while pulses are in flight.
      configure(8'h0A, 4'd5, 3'd0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 5'h1F);
      for (int k = 0; k < 4; k++) cycle(1'b0, 5'd0);
      applyStimulus(1'b1, 1'b1, 8'hFF, 4'hF, 3'd7, 1'b0, 5'd0);
      cur_cab = 8'd0; cur_l1f = 4'd0; cur_kill = 3'd0;
      busy_n = BUSY ? 1 : 0;
      quiet  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         cycle(1'b0, 5'd0);
         if (BUSY) busy_n++;
         if (L1A_DLY || LCT_DLY != 5'd0) quiet = 1'b0;
      end
      checkOutput("midrun_busy_len", busy_n, 32);
      checkOutput("midrun_quiet", quiet, 1);
      checkOutput("midrun_cnt", L1A_CNT, 0);
      cycle(1'b1, 5'b00100);
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);
      checkOutput("cleared_l1a", L1A_DLY, 1);
      checkOutput("cleared_lct", LCT_DLY, 5'b00100);

      // Randomised traffic with occasional reconfiguration and reset.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            applyStimulus(1'b1, 1'b0, cur_cab, cur_l1f, cur_kill, 1'($urandom_range(0, 1)), 5'($urandom));
         end else if ($urandom_range(0, 59) == 0) begin
            cur_cab  = 8'($urandom);
            cur_l1f  = 4'($urandom);
            cur_kill = 3'($urandom);
            applyStimulus(1'b0, 1'b1, cur_cab, cur_l1f, cur_kill, 1'($urandom_range(0, 1)), 5'($urandom));
         end else begin
            cycle(($urandom_range(0, 3) == 0), 5'($urandom));
         end
      end

      // Counter wrap: continuous L1A from a fresh reset.
      cur_cab = 8'd0; cur_l1f = 4'd0; cur_kill = 3'd0;
      applyStimulus(1'b1, 1'b0, 8'd0, 4'd0, 3'd0, 1'b0, 5'd0);
      for (int k = 0; k < 33; k++) cycle(1'b0, 5'd0);
      for (int j = 0; j <= 65539; j++) begin
         cycle(1'b1, 5'd0);
         if (j == 65537) checkOutput("cnt_ffff", L1A_CNT, 16'hFFFF);
         if (j == 65538) checkOutput("cnt_wrap0", L1A_CNT, 16'h0000);
      end
      cycle(1'b0, 5'd0);
      cycle(1'b0, 5'd0);

      @(posedge CLKCMS);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
